sync_fifo_buf: RTL and testbench
================================

SYNC_FIFO_BUF -- requirements
Module: sync_fifo_buf

Interface
REQ-001 Parameter DATASIZE, default 8, data word width in bits.
REQ-002 Parameter ADDRSIZE, default 3, address width; depth DEPTH = 2**ADDRSIZE words.
REQ-003 Parameter AFULL_TH, default 2**ADDRSIZE - 2; walmost_full asserts when count >= AFULL_TH.
REQ-004 Parameter AEMPTY_TH, default 2; ralmost_empty asserts when count <= AEMPTY_TH.
REQ-005 Port clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 Port wdata, input, DATASIZE bits: write data.
REQ-008 Port winc, input, 1 bit: write request.
REQ-009 Port rinc, input, 1 bit: read request.
REQ-010 Port rdata, output, DATASIZE bits: registered read data.
REQ-011 Port rvalid, output, 1 bit: rdata holds a newly popped word this cycle.
REQ-012 Port wfull, output, 1 bit: FIFO holds DEPTH words.
REQ-013 Port rempty, output, 1 bit: FIFO holds 0 words.
REQ-014 Port walmost_full, output, 1 bit: count >= AFULL_TH.
REQ-015 Port ralmost_empty, output, 1 bit: count <= AEMPTY_TH.
REQ-016 Port count, output, ADDRSIZE+1 bits: stored word count, 0..DEPTH.
REQ-017 Port overflow, output, 1 bit: one-cycle pulse, write rejected.
REQ-018 Port underflow, output, 1 bit: one-cycle pulse, read rejected.

Function
REQ-019 Storage SHALL be a DEPTH x DATASIZE register array, written only on accepted writes; unwritten or rejected cycles SHALL leave contents unchanged (no zero-fill).
REQ-020 Write and read pointers SHALL be ADDRSIZE+1 bits; the low ADDRSIZE bits address memory, the MSB distinguishes wrap laps.
REQ-021 Write accepted when winc=1 and wfull=0 (flag value before the edge): mem[wptr] <= wdata, wptr increments modulo 2**(ADDRSIZE+1).
REQ-022 Read accepted when rinc=1 and rempty=0: rdata <= mem[rptr] at that edge, rptr increments, rvalid=1 the following cycle (latency 1 clock).
REQ-023 rvalid SHALL be 0 in any cycle following a non-accepted read; rdata SHALL hold its last value when no read is accepted.
REQ-024 rempty SHALL equal (wptr == rptr); wfull SHALL equal (low bits equal and MSBs differ); both registered-consistent with pointers, updated the same edge as the pointer change.
REQ-025 count SHALL equal wptr - rptr (ADDRSIZE+1-bit modular subtraction); +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write.
REQ-026 Simultaneous winc and rinc when full: read accepted, write rejected, overflow=1 next cycle, count becomes DEPTH-1.
REQ-027 Simultaneous winc and rinc when empty: write accepted, read rejected, underflow=1 next cycle, count becomes 1, no read-through of new data.
REQ-028 Simultaneous accepted read and write in any other state: both complete; same-address hazard impossible since read uses rptr != wptr.
REQ-029 overflow and underflow SHALL be registered single-cycle pulses, not sticky, asserted the cycle after the rejected request.
REQ-030 walmost_full and ralmost_empty SHALL be derived combinationally from count.
REQ-031 Pointer wrap-around past 2**(ADDRSIZE+1)-1 SHALL return to 0 with flags and count continuous.

Reset
REQ-032 On rst=1 at a rising edge: wptr=0, rptr=0, rdata=0, rvalid=0, overflow=0, underflow=0; hence count=0, rempty=1, wfull=0, ralmost_empty=1, walmost_full=0.
REQ-033 Reset SHALL override winc/rinc in the same cycle; memory contents are not reset and SHALL NOT be observable after reset until rewritten.
REQ-034 Reset mid-operation SHALL discard all stored words; the first read after reset returns the first word written after reset.

Verification (DATASIZE=8, ADDRSIZE=3, defaults)
REQ-035 Reset, write 0xF2,0xFA,0xE2 -> count=3; three reads -> rdata 0xF2,0xFA,0xE2 each with rvalid=1 one cycle after rinc; rempty=1 after third.
REQ-036 Write 8 words 0x10..0x17 -> wfull=1, walmost_full=1 from count=6; 9th write 0xAA -> overflow pulse, count stays 8, reads return 0x10..0x17.
REQ-037 rinc on empty after reset -> underflow pulse for one cycle, rvalid=0, rdata=0x00, count=0.
REQ-038 At full, winc=rinc=1 with wdata=0x55 -> overflow=1, count=7, rdata=oldest word; at empty, winc=rinc=1 -> underflow=1, count=1.
REQ-039 Stream 20 words with concurrent reads over several pointer wraps -> output order equals input order, count never exceeds 8, no spurious flags.
REQ-040 Load 5 words, assert rst for one cycle with winc=1 -> count=0, rempty=1; write 0x65, read -> rdata=0x65.

Source files
------------

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO with registered read data, occupancy count, watermark
// flags and one-cycle overflow/underflow pulses. Pointers carry one extra
// lap bit so full and empty are told apart without a separate counter.
module sync_fifo_buf #(
  parameter int DATASIZE  = 8,
  parameter int ADDRSIZE  = 3,
  parameter int AFULL_TH  = 2**ADDRSIZE - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                winc,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                wfull,
  output logic                rempty,
  output logic                walmost_full,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 2**ADDRSIZE;
  localparam int PW    = ADDRSIZE + 1;
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

  logic [DATASIZE-1:0] mem_q [DEPTH];

  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic [DATASIZE-1:0] rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic                full_s, empty_s, wr_en, rd_en;
  logic [ADDRSIZE-1:0] waddr, raddr;

  // Status decode from the pointer registers; flags move on the same edge as the pointers.
  always_comb begin
    waddr   = wptr_q[ADDRSIZE-1:0];
    raddr   = rptr_q[ADDRSIZE-1:0];
    empty_s = (wptr_q == rptr_q);
    full_s  = (waddr == raddr) && (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]);
    wr_en   = winc && !full_s;
    rd_en   = rinc && !empty_s;
  end

  // Next-state: pointer advance, read data capture and rejected-request pulses.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    overflow_d  = winc && full_s;
    underflow_d = rinc && empty_s;
    if (wr_en) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (rd_en) begin
      rptr_d   = rptr_q + PW'(1);
      rdata_d  = mem_q[raddr];
      rvalid_d = 1'b1;
    end
  end

  // Control registers; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not cleared by reset; stale words are unreachable because both pointers restart at 0.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Outputs: count by modular pointer difference, watermarks straight from count.
  always_comb begin
    count         = wptr_q - rptr_q;
    rdata         = rdata_q;
    rvalid        = rvalid_q;
    wfull         = full_s;
    rempty        = empty_s;
    overflow      = overflow_q;
    underflow     = underflow_q;
    walmost_full  = (count >= AFULL_C);
    ralmost_empty = (count <= AEMPTY_C);
  end

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Bench for sync_fifo_buf: queue-based reference model compared every cycle,
// plus directed scenarios with literal expected values.
module tb_sync_fifo_buf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wdata = '0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, wfull, rempty, walmost_full, ralmost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo_buf #(.DATASIZE(8), .ADDRSIZE(3)) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc),
    .rdata(rdata), .rvalid(rvalid), .wfull(wfull), .rempty(rempty),
    .walmost_full(walmost_full), .ralmost_empty(ralmost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the registered outputs.
  logic [7:0] mq[$];
  logic [7:0] m_rdata;
  logic       m_rvalid, m_ovf, m_unf;
  logic       model_ok = 1'b0;

  // At each falling edge: compare DUT with the model state left by the last
  // rising edge, then advance the model with the inputs the next edge will see.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_rdata", rdata, m_rdata);
      chk("m_rvalid", rvalid, m_rvalid);
      chk("m_count", count, mq.size());
      chk("m_wfull", wfull, mq.size() == 8);
      chk("m_rempty", rempty, mq.size() == 0);
      chk("m_afull", walmost_full, mq.size() >= 6);
      chk("m_aempty", ralmost_empty, mq.size() <= 2);
      chk("m_ovf", overflow, m_ovf);
      chk("m_unf", underflow, m_unf);
    end
    if (rst) begin
      mq.delete();
      m_rdata  = 8'h00;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_ovf    = winc && (mq.size() == 8);
      m_unf    = rinc && (mq.size() == 0);
      m_rvalid = rinc && (mq.size() != 0);
      if (m_rvalid) m_rdata = mq.pop_front();
      if (winc && !m_ovf) mq.push_back(wdata);
    end
  end

  // One clock with the given request pattern; returns just after the rising edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    winc  = w;
    wdata = d;
    rinc  = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step(0, 8'h00, 0);
    step(1, 8'hEE, 1);
    rst = 1'b0;
    step(0, 8'h00, 0);
    chk("rst_count", count, 0);
    chk("rst_rempty", rempty, 1);
    chk("rst_aempty", ralmost_empty, 1);
    chk("rst_wfull", wfull, 0);
    chk("rst_afull", walmost_full, 0);
    chk("rst_rdata", rdata, 8'h00);

    // Read on empty
    step(0, 8'h00, 1);
    chk("unf_pulse", underflow, 1);
    chk("unf_rvalid", rvalid, 0);
    chk("unf_rdata", rdata, 8'h00);
    chk("unf_count", count, 0);
    step(0, 8'h00, 0);
    chk("unf_clear", underflow, 0);

    // Three writes then three reads
    step(1, 8'hF2, 0);
    step(1, 8'hFA, 0);
    step(1, 8'hE2, 0);
    chk("w3_count", count, 3);
    step(0, 8'h00, 1);
    chk("r1_rvalid", rvalid, 1);
    chk("r1_rdata", rdata, 8'hF2);
    step(0, 8'h00, 1);
    chk("r2_rdata", rdata, 8'hFA);
    step(0, 8'h00, 1);
    chk("r3_rdata", rdata, 8'hE2);
    chk("r3_rempty", rempty, 1);
    step(0, 8'h00, 0);
    chk("r3_rvalid_drop", rvalid, 0);
    chk("r3_rdata_hold", rdata, 8'hE2);

    // Fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      step(1, 8'h10 + 8'(i), 0);
      if (i == 4) chk("afull_at5", walmost_full, 0);
      if (i == 5) chk("afull_at6", walmost_full, 1);
    end
    chk("full_flag", wfull, 1);
    chk("full_count", count, 8);
    step(1, 8'hAA, 0);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 8);
    step(0, 8'h00, 0);
    chk("ovf_clear", overflow, 0);

    // Simultaneous request while full: read wins, write rejected
    step(1, 8'h55, 1);
    chk("fullrw_ovf", overflow, 1);
    chk("fullrw_count", count, 7);
    chk("fullrw_rdata", rdata, 8'h10);
    for (int i = 1; i < 8; i++) begin
      step(0, 8'h00, 1);
      chk("drain_rdata", rdata, 8'h10 + 8'(i));
    end
    chk("drain_empty", rempty, 1);

    // Simultaneous request while empty: write wins, read rejected
    step(1, 8'h99, 1);
    chk("emptyrw_unf", underflow, 1);
    chk("emptyrw_count", count, 1);
    chk("emptyrw_rvalid", rvalid, 0);
    step(0, 8'h00, 1);
    chk("emptyrw_read", rdata, 8'h99);

    // Stream with concurrent reads across several pointer wraps
    for (int i = 0; i < 26; i++) begin
      step(i < 20, 8'h30 + 8'(i), (i >= 3) && (i % 4 != 1));
    end
    for (int i = 0; i < 10; i++) step(0, 8'h00, 1);

    // Mixed traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset mid-operation discards contents
    step(0, 8'h00, 0);
    for (int i = 0; i < 10; i++) step(0, 8'h00, 1);
    for (int i = 0; i < 5; i++) step(1, 8'h70 + 8'(i), 0);
    rst = 1'b1;
    step(1, 8'hBB, 0);
    rst = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rempty", rempty, 1);
    step(1, 8'h65, 0);
    step(0, 8'h00, 1);
    chk("post_rst_rdata", rdata, 8'h65);
    chk("post_rst_rvalid", rvalid, 1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
